demux1_4_buf: RTL and testbench



---
 rtl/demux1_4_buf.sv | 113 +++++++++++
 tb/tb_demux1_4_buf.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/demux1_4_buf.sv
// rtl/demux1_4_buf.sv - 1-to-4 routing demux with a one-entry valid/ready holding register per port
module demux1_4_buf #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel0,
    input  logic             in_sel1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] o00,
    output logic [WIDTH-1:0] o01,
    output logic [WIDTH-1:0] o10,
    output logic [WIDTH-1:0] o11,
    output logic             v00,
    output logic             v01,
    output logic             v10,
    output logic             v11,
    input  logic             r00,
    input  logic             r01,
    input  logic             r10,
    input  logic             r11,
    output logic [CNT_W-1:0] c00,
    output logic [CNT_W-1:0] c01,
    output logic [CNT_W-1:0] c10,
    output logic [CNT_W-1:0] c11
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } port_state_e;

    port_state_e      state_q [4];
    port_state_e      state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];

    logic [1:0] sel;
    logic [3:0] port_rdy;
    logic [3:0] port_v;
    logic [3:0] port_acc;
    logic [3:0] port_drain;
    logic       accept;

    assign sel      = {in_sel1, in_sel0};
    assign port_rdy = {r11, r10, r01, r00};

    // Readiness looks only at the selected port so a stalled neighbour never blocks input.
    assign in_ready = reset_n & (~port_v[sel] | port_rdy[sel]);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= EMPTY;
                data_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                data_q[i]  <= data_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        port_v     = '0;
        port_acc   = '0;
        port_drain = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            data_d[i]  = data_q[i];
            cnt_d[i]   = cnt_q[i];

            port_v[i]     = (state_q[i] == FULL);
            port_acc[i]   = accept && (sel == 2'(i));
            port_drain[i] = port_v[i] && port_rdy[i];

            // A refill on the draining edge wins, keeping the port FULL at one word per cycle.
            if (port_drain[i]) begin
                cnt_d[i]   = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                state_d[i] = EMPTY;
            end
            if (port_acc[i]) begin
                data_d[i]  = in_data;
                state_d[i] = FULL;
            end
        end
    end

    assign o00 = data_q[0];
    assign o01 = data_q[1];
    assign o10 = data_q[2];
    assign o11 = data_q[3];

    assign v00 = port_v[0];
    assign v01 = port_v[1];
    assign v10 = port_v[2];
    assign v11 = port_v[3];

    assign c00 = cnt_q[0];
    assign c01 = cnt_q[1];
    assign c10 = cnt_q[2];
    assign c11 = cnt_q[3];

endmodule

// File: tb/tb_demux1_4_buf.sv
// tb/tb_demux1_4_buf.sv - directed self-checking bench for demux1_4_buf
module tb_demux1_4_buf;

    localparam int WIDTH = 64;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel0, in_sel1, in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] o00, o01, o10, o11;
    logic             v00, v01, v10, v11;
    logic             r00, r01, r10, r11;
    logic [CNT_W-1:0] c00, c01, c10, c11;

    int checks = 0;
    int errors = 0;

    demux1_4_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_sel0(in_sel0), .in_sel1(in_sel1),
        .in_valid(in_valid), .in_ready(in_ready),
        .o00(o00), .o01(o01), .o10(o10), .o11(o11),
        .v00(v00), .v01(v01), .v10(v10), .v11(v11),
        .r00(r00), .r01(r01), .r10(r10), .r11(r11),
        .c00(c00), .c01(c01), .c10(c10), .c11(c11)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [1:0] s);
        {in_sel1, in_sel0} = s;
    endtask

    initial begin
        reset_n = 1'b0; in_data = '0; in_valid = 1'b0; set_sel(2'b00);
        r00 = 0; r01 = 0; r10 = 0; r11 = 0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valids", {v11, v10, v01, v00}, 0);
        chk("rst_o00", o00, 0);
        chk("rst_counts", {c11, c10, c01, c00}, 0);

        // Reset then route
        @(negedge clk);
        reset_n = 1'b1;
        in_data = 100; set_sel(2'b00); in_valid = 1'b1;
        #1 chk("route_ready_empty", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("route_o00", o00, 100);
        chk("route_v00", v00, 1);
        chk("route_others_v", {v11, v10, v01}, 0);
        #1 chk("route_ready_sel00_full", in_ready, 0);
        set_sel(2'b01);
        #1 chk("route_ready_sel01", in_ready, 1);

        // Stall then drain
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_o00", o00, 100);
            chk("stall_v00", v00, 1);
            chk("stall_c00", c00, 0);
        end
        r00 = 1'b1;
        tick();
        r00 = 1'b0;
        chk("drain_v00", v00, 0);
        chk("drain_c00", c00, 1);

        // Full-rate stream on p11
        set_sel(2'b11); r11 = 1'b1; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = WIDTH'(k);
            #1 chk("stream_ready", in_ready, 1);
            tick();
            chk("stream_o11", o11, WIDTH'(k));
            chk("stream_v11", v11, 1);
        end
        in_valid = 1'b0;
        tick();
        r11 = 1'b0;
        chk("stream_c11", c11, 4);
        chk("stream_v11_empty", v11, 0);

        // Independence: stalled p01 does not block p10
        set_sel(2'b01); in_data = 64'h55; in_valid = 1'b1;
        tick();
        set_sel(2'b10); in_data = 7;
        #1 chk("indep_ready_p10", in_ready, 1);
        tick();
        chk("indep_o10", o10, 7);
        chk("indep_v10", v10, 1);
        set_sel(2'b01); in_data = 9;
        #1 chk("indep_ready_p01_stalled", in_ready, 0);
        tick();
        chk("indep_o01_held", o01, 64'h55);
        r01 = 1'b1;
        #1 chk("indep_ready_p01_draining", in_ready, 1);
        tick();
        in_valid = 1'b0; r01 = 1'b0;
        chk("indep_o01_new", o01, 9);
        chk("indep_v01", v01, 1);
        chk("indep_c01", c01, 1);

        // Counter wrap on p10: 256 drains with continuous refill
        set_sel(2'b10); in_data = 64'hABC; in_valid = 1'b1; r10 = 1'b1;
        repeat (256) tick();
        in_valid = 1'b0;
        chk("wrap_c10_256", c10, 0);
        chk("wrap_v10", v10, 1);
        tick();
        r10 = 1'b0;
        chk("wrap_c10_257", c10, 1);
        chk("wrap_v10_empty", v10, 0);

        // Fill all four ports, then asynchronous reset between edges
        for (int p = 0; p < 4; p++) begin
            set_sel(2'(p)); in_data = 64'hA0 + WIDTH'(p); in_valid = 1'b1;
            tick();
        end
        chk("fill_valids", {v11, v10, v01, v00}, 4'hF);
        chk("fill_o11", o11, 64'hA3);
        set_sel(2'b00); in_data = 100;
        #2 reset_n = 1'b0;
        #1;
        chk("areset_valids", {v11, v10, v01, v00}, 0);
        chk("areset_o", o00 | o01 | o10 | o11, 0);
        chk("areset_counts", {c11, c10, c01, c00}, 0);
        chk("areset_in_ready", in_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_reset_o00", o00, 100);
        chk("post_reset_v00", v00, 1);
        chk("post_reset_others_v", {v11, v10, v01}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
